// File: rtl/id_ex_ctrl_pipe.sv
// id_ex_ctrl_pipe: RV32I(+M) ID-stage control decoder fused with the ID/EX
// control pipeline register, including multi-cycle MUL/DIV EX occupancy.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   inst_i              instruction in ID
//   inst_valid_i        inst_i is real (0 = bubble)
//   stall_i             external hazard stall, holds the ID/EX register
//   flush_i             kills ID/EX contents; wins over stall_i
//   ex_o                {alu_src[1:0], alu_sel[2:0]}
//   m_o                 {memread, memwrite}
//   wb_o                {memtoreg(1=ALU), regwrite}
//   j_type_o            JALR
//   branch_o            BRANCH/JAL/JALR
//   branch_or_jalr_o    BRANCH/JALR
//   rd_o                destination register of the EX instruction
//   valid_o             EX holds a real instruction
//   illegal_o           EX instruction is illegal
//   md_start_o          one-cycle pulse when a MUL/DIV enters EX
//   md_op_o             funct3 of the MUL/DIV in EX
//   md_done_o           last EX cycle of a MUL/DIV (combinational)
//   id_stall_o          stall request to IF/ID (combinational)
module id_ex_ctrl_pipe #(
  parameter bit          EN_MEXT = 1'b1,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic        inst_valid_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [4:0]  ex_o,
  output logic [1:0]  m_o,
  output logic [1:0]  wb_o,
  output logic        j_type_o,
  output logic        branch_o,
  output logic        branch_or_jalr_o,
  output logic [4:0]  rd_o,
  output logic        valid_o,
  output logic        illegal_o,
  output logic        md_start_o,
  output logic [2:0]  md_op_o,
  output logic        md_done_o,
  output logic        id_stall_o
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  typedef struct packed {
    logic [4:0] ex;
    logic [1:0] m;
    logic [1:0] wb;
    logic       j;
    logic       br;
    logic       bj;
  } ctrl_t;

  localparam ctrl_t CTRL_R      = 12'b00000_00_11_000;
  localparam ctrl_t CTRL_OPI    = 12'b01001_00_11_000;
  localparam ctrl_t CTRL_STORE  = 12'b01010_01_00_000;
  localparam ctrl_t CTRL_LOAD   = 12'b01010_10_01_000;
  localparam ctrl_t CTRL_BRANCH = 12'b00011_00_00_011;
  localparam ctrl_t CTRL_AUIPC  = 12'b11100_00_11_000;
  localparam ctrl_t CTRL_LUI    = 12'b01100_00_11_000;
  localparam ctrl_t CTRL_JALR   = 12'b00110_00_11_111;
  localparam ctrl_t CTRL_JAL    = 12'b00101_00_11_010;
  localparam ctrl_t CTRL_MD     = 12'b00111_00_11_000;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_q;
  ctrl_t            dec_ctrl;
  logic             dec_ill;
  logic             dec_md;
  logic             md_wait;
  logic             hold;
  logic             unused_inst;

  assign unused_inst = ^inst_i[24:15];

  // Opcode decode of the ID instruction
  always_comb begin
    dec_ctrl = '0;
    dec_ill  = 1'b0;
    dec_md   = 1'b0;
    case (inst_i[6:0])
      7'b0110011: begin
        if (inst_i[31:25] == 7'b0000000 || inst_i[31:25] == 7'b0100000) begin
          dec_ctrl = CTRL_R;
        end else if (EN_MEXT && inst_i[31:25] == 7'b0000001) begin
          dec_ctrl = CTRL_MD;
          dec_md   = 1'b1;
        end else begin
          dec_ill = 1'b1;
        end
      end
      7'b0010011: dec_ctrl = CTRL_OPI;
      7'b0100011: dec_ctrl = CTRL_STORE;
      7'b0000011: dec_ctrl = CTRL_LOAD;
      7'b1100011: dec_ctrl = CTRL_BRANCH;
      7'b0010111: dec_ctrl = CTRL_AUIPC;
      7'b0110111: dec_ctrl = CTRL_LUI;
      7'b1100111: dec_ctrl = CTRL_JALR;
      7'b1101111: dec_ctrl = CTRL_JAL;
      default:    dec_ill  = 1'b1;
    endcase
    // Writes to x0 are dropped
    if (inst_i[11:7] == 5'd0) begin
      dec_ctrl.wb[0] = 1'b0;
    end
  end

  // EX still occupied by a MUL/DIV that has cycles left
  assign md_wait = (state_q == MD_BUSY) && (cnt_q != '0);
  assign hold    = stall_i || md_wait;

  // MUL/DIV sequencing next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (hold) begin
      if (md_wait) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (inst_valid_i && dec_md) begin
      state_d = MD_BUSY;
      cnt_d   = inst_i[14] ? DIV_CNT : MUL_CNT;
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ID/EX control register
  always_ff @(posedge clk) begin
    if (!rst || flush_i || (!hold && !inst_valid_i)) begin
      ctrl_q     <= '0;
      rd_o       <= '0;
      valid_o    <= 1'b0;
      illegal_o  <= 1'b0;
      md_start_o <= 1'b0;
      md_op_o    <= '0;
    end else if (hold) begin
      md_start_o <= 1'b0;
    end else begin
      ctrl_q     <= dec_ctrl;
      rd_o       <= inst_i[11:7];
      valid_o    <= 1'b1;
      illegal_o  <= dec_ill;
      md_start_o <= dec_md;
      md_op_o    <= dec_md ? inst_i[14:12] : 3'b000;
    end
  end

  assign ex_o             = ctrl_q.ex;
  assign m_o              = ctrl_q.m;
  assign wb_o             = ctrl_q.wb;
  assign j_type_o         = ctrl_q.j;
  assign branch_o         = ctrl_q.br;
  assign branch_or_jalr_o = ctrl_q.bj;

  assign md_done_o  = rst && (state_q == MD_BUSY) && (cnt_q == '0);
  assign id_stall_o = rst && hold;

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Bench for id_ex_ctrl_pipe: three instances (default, no M extension,
// single-cycle MUL) compared every cycle against an occupancy-age model,
// plus directed scenario checks.
module tb_id_ex_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i;
  logic        inst_valid_i, stall_i, flush_i;

  logic [2:0][4:0] ex_w, rd_w;
  logic [2:0][1:0] m_w, wb_w;
  logic [2:0][2:0] md_op_w;
  logic [2:0]      j_w, br_w, bj_w, val_w, ill_w, st_w, done_w, stl_w;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_MUL  = 32'h027302B3;
  localparam logic [31:0] I_DIV  = 32'h027342B3;
  localparam logic [31:0] I_JALR = 32'h000080E7;
  localparam logic [31:0] I_NOP  = 32'h00000013;
  localparam logic [6:0]  OPS [9] = '{7'b0110011, 7'b0010011, 7'b0100011,
                                      7'b0000011, 7'b1100011, 7'b0010111,
                                      7'b0110111, 7'b1100111, 7'b1101111};

  // Instance parameters as seen by the model
  int p_mul [3] = '{2, 2, 1};
  int p_div [3] = '{32, 32, 3};
  bit p_en  [3] = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  id_ex_ctrl_pipe #(.EN_MEXT(1'b1), .MUL_LAT(2), .DIV_LAT(32)) u0 (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
    .stall_i(stall_i), .flush_i(flush_i), .ex_o(ex_w[0]), .m_o(m_w[0]),
    .wb_o(wb_w[0]), .j_type_o(j_w[0]), .branch_o(br_w[0]),
    .branch_or_jalr_o(bj_w[0]), .rd_o(rd_w[0]), .valid_o(val_w[0]),
    .illegal_o(ill_w[0]), .md_start_o(st_w[0]), .md_op_o(md_op_w[0]),
    .md_done_o(done_w[0]), .id_stall_o(stl_w[0]));

  id_ex_ctrl_pipe #(.EN_MEXT(1'b0), .MUL_LAT(2), .DIV_LAT(32)) u1 (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
    .stall_i(stall_i), .flush_i(flush_i), .ex_o(ex_w[1]), .m_o(m_w[1]),
    .wb_o(wb_w[1]), .j_type_o(j_w[1]), .branch_o(br_w[1]),
    .branch_or_jalr_o(bj_w[1]), .rd_o(rd_w[1]), .valid_o(val_w[1]),
    .illegal_o(ill_w[1]), .md_start_o(st_w[1]), .md_op_o(md_op_w[1]),
    .md_done_o(done_w[1]), .id_stall_o(stl_w[1]));

  id_ex_ctrl_pipe #(.EN_MEXT(1'b1), .MUL_LAT(1), .DIV_LAT(3)) u2 (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
    .stall_i(stall_i), .flush_i(flush_i), .ex_o(ex_w[2]), .m_o(m_w[2]),
    .wb_o(wb_w[2]), .j_type_o(j_w[2]), .branch_o(br_w[2]),
    .branch_or_jalr_o(bj_w[2]), .rd_o(rd_w[2]), .valid_o(val_w[2]),
    .illegal_o(ill_w[2]), .md_start_o(st_w[2]), .md_op_o(md_op_w[2]),
    .md_done_o(done_w[2]), .id_stall_o(stl_w[2]));

  // Model of what EX holds, per instance
  logic [11:0] m_bun [3];
  logic [4:0]  m_rd  [3];
  logic        m_val [3], m_ill [3], m_st [3];
  logic [2:0]  m_op  [3];
  bit          m_in  [3];
  int          m_age [3], m_lat [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // {ex,m,wb,j,br,bj, illegal, is_muldiv} straight from the decode table
  function automatic logic [13:0] ref_dec(input logic [31:0] ins, input bit en);
    logic [11:0] b;
    logic        ill, md;
    b = '0; ill = 1'b0; md = 1'b0;
    case (ins[6:0])
      7'b0110011:
        if (ins[31:25] == 7'b0000000 || ins[31:25] == 7'b0100000) b = 12'b00000_00_11_000;
        else if (ins[31:25] == 7'b0000001 && en) begin b = 12'b00111_00_11_000; md = 1'b1; end
        else ill = 1'b1;
      7'b0010011: b = 12'b01001_00_11_000;
      7'b0100011: b = 12'b01010_01_00_000;
      7'b0000011: b = 12'b01010_10_01_000;
      7'b1100011: b = 12'b00011_00_00_011;
      7'b0010111: b = 12'b11100_00_11_000;
      7'b0110111: b = 12'b01100_00_11_000;
      7'b1100111: b = 12'b00110_00_11_111;
      7'b1101111: b = 12'b00101_00_11_010;
      default:    ill = 1'b1;
    endcase
    if (ins[11:7] == 5'd0) b[3] = 1'b0;
    return {b, ill, md};
  endfunction

  function automatic logic [24:0] obs(input int k);
    return {ex_w[k], m_w[k], wb_w[k], j_w[k], br_w[k], bj_w[k], rd_w[k],
            val_w[k], ill_w[k], st_w[k], md_op_w[k], done_w[k], stl_w[k]};
  endfunction

  function automatic logic [24:0] expv(input int k);
    logic busy_left, done;
    busy_left = m_in[k] && (m_age[k] < m_lat[k] - 1);
    done      = rst && m_in[k] && (m_age[k] >= m_lat[k] - 1);
    return {m_bun[k], m_rd[k], m_val[k], m_ill[k], m_st[k], m_op[k], done,
            rst && (stall_i || busy_left)};
  endfunction

  task automatic model_clear(input int k);
    m_bun[k] = '0; m_rd[k] = '0; m_val[k] = 1'b0; m_ill[k] = 1'b0;
    m_st[k] = 1'b0; m_op[k] = '0; m_in[k] = 1'b0; m_age[k] = 0; m_lat[k] = 1;
  endtask

  task automatic model_upd(input int k);
    logic [13:0] d;
    bit busy_left;
    busy_left = m_in[k] && (m_age[k] < m_lat[k] - 1);
    if (!rst || flush_i) model_clear(k);
    else if (stall_i || busy_left) begin
      m_st[k] = 1'b0;
      if (m_in[k] && m_age[k] < 1000) m_age[k]++;
    end else if (inst_valid_i) begin
      d = ref_dec(inst_i, p_en[k]);
      m_bun[k] = d[13:2]; m_ill[k] = d[1]; m_st[k] = d[0];
      m_rd[k] = inst_i[11:7]; m_val[k] = 1'b1;
      m_op[k] = d[0] ? inst_i[14:12] : 3'b000;
      m_in[k] = d[0]; m_age[k] = 0;
      m_lat[k] = inst_i[14] ? p_div[k] : p_mul[k];
    end else model_clear(k);
  endtask

  // One clock: drive at negedge, compare, advance model at posedge
  task automatic step(input logic r, input logic v, input logic s, input logic f,
                      input logic [31:0] ins, input bit do_chk);
    rst = r; inst_valid_i = v; stall_i = s; flush_i = f; inst_i = ins;
    #1;
    if (do_chk) for (int k = 0; k < 3; k++) chk($sformatf("u%0d_cycle", k), 32'(obs(k)), 32'(expv(k)));
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_upd(k);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: r[6:0] = OPS[$urandom_range(0, 8)];
      6: begin r[6:0] = 7'b0110011; r[31:25] = 7'b0000001; end
      7: begin r[6:0] = 7'b0110011; r[31:25] = ($urandom_range(0, 1) == 0) ? 7'b0000000 : 7'b0100000; end
      8: r = 32'hFFFFFFFF;
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
    return r;
  endfunction

  initial begin
    int cnt_s, cnt_d2;
    for (int k = 0; k < 3; k++) model_clear(k);
    rst = 1'b0; inst_valid_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; inst_i = I_ADD;
    @(negedge clk);

    // Reset held two clocks, then release and load add x1
    step(1'b0, 1'b1, 1'b0, 1'b0, I_ADD, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, I_ADD, 1'b1);
    chk("t1_rst_valid", 32'(val_w[0]), 32'd0);
    chk("t1_rst_wb", 32'(wb_w[0]), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, I_ADD, 1'b1);
    chk("t1_ex", 32'(ex_w[0]), 32'd0);
    chk("t1_wb", 32'(wb_w[0]), 32'b11);
    chk("t1_rd", 32'(rd_w[0]), 32'd1);
    chk("t1_valid", 32'(val_w[0]), 32'd1);

    // MUL: one stall cycle on u0, none on u1 (illegal) or u2 (single cycle)
    step(1'b1, 1'b1, 1'b0, 1'b0, I_MUL, 1'b1);
    chk("t2_start", 32'(st_w[0]), 32'd1);
    chk("t2_start_lat1_done", 32'({st_w[2], done_w[2]}), 32'b11);
    chk("t6_ill", 32'({ill_w[1], val_w[1], st_w[1], stl_w[1]}), 32'b1100);
    cnt_s = int'(stl_w[0]); cnt_d2 = int'(done_w[0]);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, I_NOP, 1'b1);
      cnt_s += int'(stl_w[0]); cnt_d2 += int'(done_w[0]);
    end
    chk("t2_stall_cycles", 32'(cnt_s), 32'd1);
    chk("t2_done_cycles", 32'(cnt_d2), 32'd1);

    // DIV: 31 stall cycles, funct3 100
    step(1'b1, 1'b1, 1'b0, 1'b0, I_DIV, 1'b1);
    chk("t3_op", 32'(md_op_w[0]), 32'b100);
    cnt_s = int'(stl_w[0]);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, I_NOP, 1'b1);
      cnt_s += int'(stl_w[0]);
    end
    chk("t3_stall_cycles", 32'(cnt_s), 32'd31);

    // DIV aborted by flush
    step(1'b1, 1'b1, 1'b0, 1'b0, I_DIV, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, 1'b0, I_NOP, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, I_NOP, 1'b1);
    inst_valid_i = 1'b0; #1;
    chk("t3_flush", 32'({val_w[0], stl_w[0], done_w[0]}), 32'b000);
    step(1'b1, 1'b0, 1'b0, 1'b0, I_NOP, 1'b1);

    // JALR held under stall, then flush wins over stall
    step(1'b1, 1'b1, 1'b0, 1'b0, I_JALR, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, I_ADD, 1'b1);
      chk("t4_hold", 32'({ex_w[0], j_w[0], br_w[0], bj_w[0]}), 32'b00110_111);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1, I_ADD, 1'b1);
    chk("t4_flush", 32'({val_w[0], ex_w[0], br_w[0]}), 32'd0);

    // ADDI x0 and an all-ones illegal word
    step(1'b1, 1'b1, 1'b0, 1'b0, I_NOP, 1'b1);
    chk("t5_addi", 32'({ex_w[0], wb_w[0]}), 32'b01001_10);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1);
    chk("t5_ill", 32'({ill_w[0], val_w[0], ex_w[0], m_w[0], wb_w[0]}), 32'b11_00000_00_00);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
           ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0,
           rnd_inst(), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
